// File: rtl/slc3_io_pkg.sv
// Shared types, constants and the seven-segment decoder for the SLC-3 I/O unit.
package slc3_io_pkg;

    typedef enum logic [1:0] {IDLE, WAIT_PRESS, WAIT_RELEASE} io_state_t;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;
    localparam logic [6:0]  SEG_BLANK       = 7'h7F;

    // Active-low segments, bit order gfedcba.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Synchronises and debounces an active-low push button; reports the stable
// level and one-cycle pulses on each accepted press and release.
module io_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic raw_n,
    output logic level_pressed,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CW = $clog2(DEB_CYCLES);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only runs while the synced input disagrees with the accepted level.
    always_comb begin
        cnt_d         = '0;
        level_d       = level_q;
        press_pulse   = 1'b0;
        release_pulse = 1'b0;
        if (~sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d       = ~level_q;
                press_pulse   = ~level_q;
                release_pulse = level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_n;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_pressed = level_q;

endmodule

// File: rtl/slc3_io_unit.sv
// Memory-mapped switch/hex register plus the Continue-button pause handshake
// for the SLC-3 top level.
module slc3_io_unit
    import slc3_io_pkg::*;
#(
    parameter int          SW_W       = 10,
    parameter int          NUM_HEX    = 4,
    parameter int          LED_W      = 10,
    parameter int          DEB_CYCLES = 50000,
    parameter logic [15:0] IO_ADDR    = IO_ADDR_DEFAULT
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [SW_W-1:0]      sw_in,
    input  logic                 continue_n,
    input  logic                 mem_sel,
    input  logic                 mem_we,
    input  logic [15:0]          mem_addr,
    input  logic [15:0]          mem_wdata,
    output logic [15:0]          mem_rdata,
    output logic                 mem_ack,
    input  logic                 pause_req,
    input  logic [LED_W-1:0]     pause_code,
    output logic                 pause_done,
    output logic [LED_W-1:0]     led,
    output logic [7*NUM_HEX-1:0] hex_seg
);

    localparam int HEX_W = 4 * NUM_HEX;

    logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
    logic [15:0]      rdata_q, rdata_d;
    logic             ack_q, ack_d;
    logic [HEX_W-1:0] hex_q, hex_d;
    io_state_t        state_q, state_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             done_q, done_d;
    logic             accept;
    logic             level_pressed, press_pulse, release_pulse;

    io_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .Clk           (Clk),
        .Reset         (Reset),
        .raw_n         (continue_n),
        .level_pressed (level_pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    assign accept = mem_sel && (mem_addr == IO_ADDR);

    always_comb begin
        ack_d   = accept;
        rdata_d = rdata_q;
        hex_d   = hex_q;
        if (accept) begin
            if (mem_we) hex_d   = mem_wdata[HEX_W-1:0];
            else        rdata_d = 16'(sw_sync_q);
        end
    end

    // Only debounced edges advance the handshake, so a button held on entry is ignored.
    always_comb begin
        state_d = state_q;
        led_d   = led_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pause_req) begin
                    state_d = WAIT_PRESS;
                    led_d   = pause_code;
                end
            end
            WAIT_PRESS: begin
                if (!pause_req) begin
                    state_d = IDLE;
                    led_d   = '0;
                end else if (press_pulse) begin
                    state_d = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                if (!pause_req) begin
                    state_d = IDLE;
                    led_d   = '0;
                end else if (release_pulse && level_pressed) begin
                    state_d = IDLE;
                    led_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                led_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            hex_q     <= '0;
            state_q   <= IDLE;
            led_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            hex_q     <= hex_d;
            state_q   <= state_d;
            led_q     <= led_d;
            done_q    <= done_d;
        end
    end

    genvar g;
    for (g = 0; g < NUM_HEX; g++) begin : g_digit
        assign hex_seg[7*g +: 7] = hex_to_seg(hex_q[4*g +: 4]);
    end

    assign mem_rdata  = rdata_q;
    assign mem_ack    = ack_q;
    assign pause_done = done_q;
    assign led        = led_q;

endmodule

// File: tb/tb_slc3_io_unit.sv
// Self-checking bench for slc3_io_unit: directed scenarios plus random traffic
// compared against a behavioural model of the bus, debounce window and pause handshake.
module tb_slc3_io_unit;

    localparam int DEB = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [9:0]  sw_in = '0;
    logic        continue_n = 1'b1;
    logic        mem_sel = 1'b0;
    logic        mem_we = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [15:0] mem_wdata = '0;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        pause_req = 1'b0;
    logic [9:0]  pause_code = '0;
    logic        pause_done;
    logic [9:0]  led;
    logic [27:0] hex_seg;

    int checks = 0;
    int errors = 0;

    slc3_io_unit #(.SW_W(10), .NUM_HEX(4), .LED_W(10), .DEB_CYCLES(DEB), .IO_ADDR(16'hFFFF)) dut (
        .Clk(Clk), .Reset(Reset), .sw_in(sw_in), .continue_n(continue_n),
        .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pause_req(pause_req),
        .pause_code(pause_code), .pause_done(pause_done), .led(led), .hex_seg(hex_seg)
    );

    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [9:0]  m_sw1, m_sw2;
    logic [15:0] m_rdata, m_hex;
    logic        m_ack, m_c1, m_c2, m_lvl, m_done, m_flip;
    bit          m_win [DEB];
    int          m_phase;
    logic [9:0]  m_led;

    function automatic logic [27:0] exp_seg(input logic [15:0] h);
        logic [27:0] r;
        for (int i = 0; i < 4; i++) r[7*i +: 7] = seg_tab[h[4*i +: 4]];
        return r;
    endfunction

    // A level change is accepted once the last DEB synced samples all disagree with it.
    always_comb begin
        m_flip = ((!m_c2) != m_lvl);
        for (int i = 0; i < DEB - 1; i++) if (m_win[i] == m_lvl) m_flip = 1'b0;
    end

    always @(posedge Clk) begin
        if (Reset) begin
            m_sw1 <= '0; m_sw2 <= '0; m_rdata <= '0; m_hex <= '0; m_ack <= 1'b0;
            m_c1 <= 1'b1; m_c2 <= 1'b1; m_lvl <= 1'b0; m_done <= 1'b0;
            m_phase <= 0; m_led <= '0;
            for (int i = 0; i < DEB; i++) m_win[i] <= 1'b0;
        end else begin
            m_sw1 <= sw_in;
            m_sw2 <= m_sw1;
            m_ack <= mem_sel && (mem_addr == 16'hFFFF);
            if (mem_sel && mem_addr == 16'hFFFF) begin
                if (mem_we) m_hex <= mem_wdata;
                else        m_rdata <= {6'b0, m_sw2};
            end
            m_c1 <= continue_n;
            m_c2 <= m_c1;
            for (int i = DEB - 1; i > 0; i--) m_win[i] <= m_win[i-1];
            m_win[0] <= !m_c2;
            if (m_flip) m_lvl <= !m_lvl;
            m_done <= 1'b0;
            case (m_phase)
                0: if (pause_req) begin m_phase <= 1; m_led <= pause_code; end
                1: if (!pause_req) begin m_phase <= 0; m_led <= '0; end
                   else if (m_flip && !m_lvl) m_phase <= 2;
                default: if (!pause_req) begin m_phase <= 0; m_led <= '0; end
                   else if (m_flip && m_lvl) begin m_phase <= 0; m_led <= '0; m_done <= 1'b1; end
            endcase
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset = 1'b1;
        cyc(); cyc();
        checks++; if (hex_seg !== {4{7'h40}}) begin errors++; $display("FAIL reset_hex got %h want %h", hex_seg, {4{7'h40}}); end
        checks++; if (led !== 10'h0) begin errors++; $display("FAIL reset_led got %h want 0", led); end
        checks++; if (mem_ack !== 1'b0 || pause_done !== 1'b0) begin errors++; $display("FAIL reset_pulses ack=%b done=%b want 0 0", mem_ack, pause_done); end
        checks++; if (mem_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", mem_rdata); end
        Reset = 1'b0;
    endtask

    task automatic test_switch_read();
        sw_in = 10'h145;
        cyc(); cyc(); cyc();
        mem_sel = 1'b1; mem_we = 1'b0; mem_addr = 16'hFFFF;
        cyc();
        mem_sel = 1'b0;
        checks++; if (mem_ack !== 1'b1) begin errors++; $display("FAIL sw_read_ack got %b want 1", mem_ack); end
        checks++; if (mem_rdata !== 16'h0145) begin errors++; $display("FAIL sw_read_data got %h want 0145", mem_rdata); end
        cyc();
        checks++; if (mem_ack !== 1'b0) begin errors++; $display("FAIL sw_ack_single got %b want 0", mem_ack); end
        sw_in = 10'h3AA;
        mem_sel = 1'b1; mem_addr = 16'hFFFE;
        cyc();
        mem_sel = 1'b0;
        checks++; if (mem_ack !== 1'b0 || mem_rdata !== 16'h0145) begin errors++; $display("FAIL miss_addr ack=%b data=%h want 0 0145", mem_ack, mem_rdata); end
    endtask

    task automatic test_hex_write();
        mem_sel = 1'b1; mem_we = 1'b1; mem_addr = 16'hFFFF; mem_wdata = 16'h1A2F;
        cyc();
        mem_sel = 1'b0; mem_we = 1'b0;
        checks++; if (mem_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got %b want 1", mem_ack); end
        checks++; if (hex_seg !== {7'h79, 7'h08, 7'h24, 7'h0E}) begin errors++; $display("FAIL wr_hex got %h want %h", hex_seg, {7'h79, 7'h08, 7'h24, 7'h0E}); end
        checks++; if (mem_rdata !== 16'h0145) begin errors++; $display("FAIL wr_rdata_hold got %h want 0145", mem_rdata); end
    endtask

    task automatic test_bus_random();
        for (int n = 0; n < 400; n++) begin
            mem_sel   = ($urandom_range(0, 3) != 0);
            mem_we    = $urandom_range(0, 1);
            mem_addr  = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'($urandom);
            mem_wdata = 16'($urandom);
            if ($urandom_range(0, 4) == 0) sw_in = 10'($urandom);
            cyc();
            checks++; if (mem_ack !== m_ack) begin errors++; $display("FAIL bus_ack n=%0d got %b want %b", n, mem_ack, m_ack); end
            checks++; if (mem_rdata !== m_rdata) begin errors++; $display("FAIL bus_rdata n=%0d got %h want %h", n, mem_rdata, m_rdata); end
            checks++; if (hex_seg !== exp_seg(m_hex)) begin errors++; $display("FAIL bus_hex n=%0d got %h want %h", n, hex_seg, exp_seg(m_hex)); end
        end
        mem_sel = 1'b0; mem_we = 1'b0;
    endtask

    task automatic test_pause();
        int dones;
        pause_code = 10'h7; pause_req = 1'b1;
        cyc();
        checks++; if (led !== 10'h7) begin errors++; $display("FAIL pause_led got %h want 007", led); end
        continue_n = 1'b0; cyc(); cyc(); continue_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            checks++; if (pause_done !== 1'b0 || led !== 10'h7) begin errors++; $display("FAIL glitch i=%0d done=%b led=%h want 0 007", i, pause_done, led); end
        end
        dones = 0;
        for (int i = 0; i < 24; i++) begin
            continue_n = (i < 8) ? 1'b0 : 1'b1;
            cyc();
            checks++; if (pause_done !== m_done || led !== m_led) begin errors++; $display("FAIL pause_seq i=%0d done=%b led=%h want %b %h", i, pause_done, led, m_done, m_led); end
            if (pause_done === 1'b1) begin
                dones++;
                checks++; if (i < 10 || led !== 10'h0) begin errors++; $display("FAIL pause_done_when i=%0d led=%h want i>=10 led 0", i, led); end
                pause_req = 1'b0;
            end
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL pause_done_count got %0d want 1", dones); end
        pause_req = 1'b0;
        cyc();
    endtask

    task automatic test_two_pauses();
        int dones;
        bit released;
        pause_code = 10'($urandom); pause_req = 1'b1;
        dones = 0;
        // first pause: press then release
        for (int i = 0; i < 40 && dones == 0; i++) begin
            continue_n = (i < 8) ? 1'b0 : 1'b1;
            cyc();
            checks++; if (pause_done !== m_done || led !== m_led) begin errors++; $display("FAIL two_p1 i=%0d done=%b led=%h want %b %h", i, pause_done, led, m_done, m_led); end
            if (pause_done === 1'b1) dones++;
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL two_p1_timeout dones=%0d want 1", dones); end
        // second pause begins immediately; hold the button long before releasing
        released = 1'b0;
        for (int i = 0; i < 60 && dones < 2; i++) begin
            continue_n = (i < 30) ? 1'b0 : 1'b1;
            cyc();
            checks++; if (pause_done !== m_done || led !== m_led) begin errors++; $display("FAIL two_p2 i=%0d done=%b led=%h want %b %h", i, pause_done, led, m_done, m_led); end
            if (i == 1) begin
                checks++; if (led !== pause_code) begin errors++; $display("FAIL two_p2_led got %h want %h", led, pause_code); end
            end
            if (pause_done === 1'b1) begin
                dones++;
                checks++; if (i < 32) begin errors++; $display("FAIL two_p2_early i=%0d want >=32", i); end
            end
        end
        checks++; if (dones != 2) begin errors++; $display("FAIL two_p2_timeout dones=%0d want 2", dones); end
        pause_req = 1'b0;
        cyc(); cyc();
    endtask

    task automatic test_held_on_entry();
        int dones;
        pause_req = 1'b0; continue_n = 1'b0;
        repeat (12) cyc();
        pause_code = 10'h2C5; pause_req = 1'b1;
        dones = 0;
        for (int i = 0; i < 30; i++) begin
            continue_n = (i < 15) ? 1'b0 : 1'b1;
            cyc();
            if (pause_done === 1'b1) dones++;
            checks++; if (led !== m_led || pause_done !== m_done) begin errors++; $display("FAIL held_entry i=%0d done=%b led=%h want %b %h", i, pause_done, led, m_done, m_led); end
        end
        checks++; if (dones != 0 || led !== 10'h2C5) begin errors++; $display("FAIL held_entry_nodone dones=%0d led=%h want 0 2c5", dones, led); end
        for (int i = 0; i < 40 && dones == 0; i++) begin
            continue_n = (i < 8) ? 1'b0 : 1'b1;
            cyc();
            if (pause_done === 1'b1) dones++;
        end
        checks++; if (dones != 1) begin errors++; $display("FAIL held_entry_done dones=%0d want 1", dones); end
        pause_req = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_pause();
        pause_code = 10'h3FF; pause_req = 1'b1; continue_n = 1'b0;
        repeat (12) cyc();
        checks++; if (led !== 10'h3FF) begin errors++; $display("FAIL rst_mid_pre led=%h want 3ff", led); end
        Reset = 1'b1; continue_n = 1'b1;
        cyc(); cyc();
        checks++; if (led !== 10'h0 || pause_done !== 1'b0 || hex_seg !== {4{7'h40}}) begin errors++; $display("FAIL rst_mid led=%h done=%b hex=%h want 0 0 %h", led, pause_done, hex_seg, {4{7'h40}}); end
        Reset = 1'b0; pause_req = 1'b0;
        for (int i = 0; i < 15; i++) begin
            cyc();
            checks++; if (pause_done !== 1'b0 || led !== 10'h0) begin errors++; $display("FAIL rst_mid_after i=%0d done=%b led=%h want 0 0", i, pause_done, led); end
        end
    endtask

    task automatic test_random();
        int seg_left;
        seg_left = 0;
        for (int n = 0; n < 4000; n++) begin
            if (seg_left == 0) begin
                continue_n = ~continue_n;
                seg_left = $urandom_range(1, 12);
            end
            seg_left--;
            if ($urandom_range(0, 39) == 0) begin
                pause_req = ~pause_req;
                pause_code = 10'($urandom);
            end
            mem_sel   = ($urandom_range(0, 2) == 0);
            mem_we    = $urandom_range(0, 1);
            mem_addr  = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'($urandom);
            mem_wdata = 16'($urandom);
            if ($urandom_range(0, 9) == 0) sw_in = 10'($urandom);
            cyc();
            checks++; if (pause_done !== m_done) begin errors++; $display("FAIL rnd_done n=%0d got %b want %b", n, pause_done, m_done); end
            checks++; if (led !== m_led) begin errors++; $display("FAIL rnd_led n=%0d got %h want %h", n, led, m_led); end
            checks++; if (mem_ack !== m_ack || mem_rdata !== m_rdata) begin errors++; $display("FAIL rnd_bus n=%0d ack=%b data=%h want %b %h", n, mem_ack, mem_rdata, m_ack, m_rdata); end
            checks++; if (hex_seg !== exp_seg(m_hex)) begin errors++; $display("FAIL rnd_hex n=%0d got %h want %h", n, hex_seg, exp_seg(m_hex)); end
        end
        mem_sel = 1'b0; pause_req = 1'b0; continue_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_switch_read();
        test_hex_write();
        test_bus_random();
        test_pause();
        test_two_pauses();
        test_held_on_entry();
        test_reset_mid_pause();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
